// File: rtl/demux_collect_pkg.sv
// Shared constants and lane index type for the lane collector and its per-lane deserializers.
// Parity framing is selected by DEMUX_LANE_COLLECTOR_PARITY_EN in the files that import this.
package demux_collect_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int NUM_LANES  = 4;

  typedef logic [1:0] lane_idx_t;

  function automatic lane_idx_t lane_next(input lane_idx_t l);
    return l + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/demux_lane_deser.sv
// Per-lane MSB-first deserializer: registered word plus a one-cycle frame_done pulse
// on the edge after the last valid bit. No backpressure; invalid cycles are ignored.
module demux_lane_deser #(
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  output logic [FRAME_LEN-1:0] frame_dat,
  output logic                 frame_done
);

  localparam int                CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bit_vld) begin
      shift_d = {shift_q[FRAME_LEN-2:0], bit_in};
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign frame_dat  = shift_q;
  assign frame_done = done_q;

endmodule

// File: rtl/demux_lane_collector.sv
// Collects serial lane frames into per-lane hold slots and round-robins them onto one valid/ready
// byte stream; out_vld 2 cycles after the last bit; DEMUX_LANE_COLLECTOR_PARITY_EN adds odd parity.
module demux_lane_collector #(
  parameter int DATA_W    = demux_collect_pkg::DEF_DATA_W,
  parameter int NUM_LANES = demux_collect_pkg::NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_bit,
  input  logic [NUM_LANES-1:0] lane_vld,
  input  logic                 out_rdy,
  input  logic                 ovf_clr,
  output logic                 out_vld,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           out_ch,
  output logic [NUM_LANES-1:0] ovf
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  ,
  output logic                 out_perr
`endif
);

  import demux_collect_pkg::*;

`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  logic [FRAME_LEN-1:0] frame_dat [NUM_LANES];
  logic [NUM_LANES-1:0] frame_done;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_deser #(.FRAME_LEN(FRAME_LEN)) u_deser (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (lane_bit[i]),
      .bit_vld   (lane_vld[i]),
      .frame_dat (frame_dat[i]),
      .frame_done(frame_done[i])
    );
  end

  logic [DATA_W-1:0]    hold_q [NUM_LANES];
  logic [DATA_W-1:0]    hold_d [NUM_LANES];
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] ovf_q, ovf_d;
  lane_idx_t            rr_ptr_q, rr_ptr_d;
  logic                 out_vld_q, out_vld_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  lane_idx_t            out_ch_q, out_ch_d;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  logic [NUM_LANES-1:0] hold_perr_q, hold_perr_d;
  logic                 out_perr_q, out_perr_d;
`endif

  logic      load;
  logic      gnt_vld;
  lane_idx_t gnt_idx;
  lane_idx_t cand;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      cand = rr_ptr_q + lane_idx_t'(k);
      if (pending_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    load       = !out_vld_q || out_rdy;
    hold_d     = hold_q;
    pending_d  = pending_q;
    ovf_d      = ovf_clr ? '0 : ovf_q;
    rr_ptr_d   = rr_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
    hold_perr_d = hold_perr_q;
    out_perr_d  = out_perr_q;
`endif

    if (load) begin
      out_vld_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d         = hold_q[gnt_idx];
        out_ch_d           = gnt_idx;
        pending_d[gnt_idx] = 1'b0;
        rr_ptr_d           = lane_next(gnt_idx);
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
        out_perr_d = hold_perr_q[gnt_idx];
`endif
      end
    end

    // A slot being granted this cycle is free to take the new byte; otherwise it is dropped.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (frame_done[i]) begin
        if (!pending_q[i] || (load && gnt_vld && gnt_idx == lane_idx_t'(i))) begin
          hold_d[i]    = frame_dat[i][FRAME_LEN-1 -: DATA_W];
          pending_d[i] = 1'b1;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
          hold_perr_d[i] = ~(^frame_dat[i]);
`endif
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '{default: '0};
      pending_q  <= '0;
      ovf_q      <= '0;
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
      hold_perr_q <= '0;
      out_perr_q  <= 1'b0;
`endif
    end else begin
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      rr_ptr_q   <= rr_ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
      hold_perr_q <= hold_perr_d;
      out_perr_q  <= out_perr_d;
`endif
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_ch   = out_ch_q;
  assign ovf      = ovf_q;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  assign out_perr = out_perr_q;
`endif

endmodule

// File: tb/tb_demux_lane_collector.sv
// Bench for demux_lane_collector: directed scenarios plus a long random run against a
// transaction-level model; honours DEMUX_LANE_COLLECTOR_PARITY_EN.
module tb_demux_lane_collector;

`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lane_bit;
  logic [3:0] lane_vld;
  logic       out_rdy;
  logic       ovf_clr;
  logic       out_vld;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic [3:0] ovf;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
  logic       out_perr;
`endif

  demux_lane_collector dut (
    .clk     (clk),
    .rst     (rst),
    .lane_bit(lane_bit),
    .lane_vld(lane_vld),
    .out_rdy (out_rdy),
    .ovf_clr (ovf_clr),
    .out_vld (out_vld),
    .out_data(out_data),
    .out_ch  (out_ch),
    .ovf     (ovf)
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
    ,
    .out_perr(out_perr)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int got_q[$];
  logic [FL-1:0] frm [4];

  // Reference model: integer bit accumulators, one-deep mailbox per lane, single output slot.
  int   m_cnt [4];
  int   m_acc [4];
  bit   m_done[4];
  int   m_dval[4];
  bit   m_full[4];
  int   m_mb  [4];
  bit   m_mbp [4];
  bit   m_vld;
  int   m_data;
  int   m_ch;
  bit   m_perr;
  int   m_rr;
  bit [3:0] m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_cnt[l] = 0; m_acc[l] = 0; m_done[l] = 0; m_dval[l] = 0;
      m_full[l] = 0; m_mb[l] = 0; m_mbp[l] = 0;
    end
    m_vld = 0; m_data = 0; m_ch = 0; m_perr = 0; m_rr = 0; m_ovf = '0;
  endtask

  task automatic model_step();
    bit take;
    bit old;
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    take = !m_vld || out_rdy;
    g = -1;
    if (take) begin
      for (int k = 0; k < 4; k++) begin
        if (m_full[(m_rr + k) % 4]) begin
          g = (m_rr + k) % 4;
          break;
        end
      end
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_data = m_mb[g]; m_ch = g; m_perr = m_mbp[g]; m_rr = (g + 1) % 4;
      end
    end
    if (ovf_clr) m_ovf = '0;
    for (int l = 0; l < 4; l++) begin
      old = m_full[l];
      if (g == l) m_full[l] = 0;
      if (m_done[l]) begin
        if (!old || g == l) begin
          m_full[l] = 1;
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
          m_mb[l]  = m_dval[l] >> 1;
          m_mbp[l] = ($countones(m_dval[l]) % 2) == 0;
`else
          m_mb[l]  = m_dval[l];
          m_mbp[l] = 0;
`endif
        end else begin
          m_ovf[l] = 1'b1;
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      m_done[l] = 0;
      if (lane_vld[l]) begin
        m_acc[l] = m_acc[l] * 2 + int'(lane_bit[l]);
        m_cnt[l]++;
        if (m_cnt[l] == FL) begin
          m_done[l] = 1; m_dval[l] = m_acc[l]; m_acc[l] = 0; m_cnt[l] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    if (out_vld === 1'b1 && out_rdy === 1'b1) got_q.push_back(int'(out_ch) * 256 + int'(out_data));
    @(posedge clk);
    model_step();
    #1;
    check_val("m_vld", 32'(out_vld), 32'(m_vld));
    check_val("m_data", 32'(out_data), 32'(m_data));
    check_val("m_ch", 32'(out_ch), 32'(m_ch));
    check_val("m_ovf", 32'(ovf), 32'(m_ovf));
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
    check_val("m_perr", 32'(out_perr), 32'(m_perr));
`endif
  endtask

  function automatic logic [FL-1:0] mk(input logic [7:0] d);
`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
    return {d, ~(^d)};
`else
    return d;
`endif
  endfunction

  // Shifts the first nbits of frm[] out on the masked lanes; gap inserts an idle cycle per bit.
  task automatic send(input logic [3:0] mask, input int nbits, input bit gap);
    for (int b = 0; b < nbits; b++) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) begin
          lane_vld[l] = 1'b1;
          lane_bit[l] = frm[l][FL-1-b];
        end
      end
      cycle();
      if (gap) begin
        lane_vld = '0;
        cycle();
      end
    end
    lane_vld = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; lane_bit = '0; lane_vld = '0; out_rdy = 1'b1; ovf_clr = 1'b0;
    model_reset();
    do_reset();
    check_val("rst_vld", 32'(out_vld), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);

    // Single byte on lane 2, latency of two edges after the last bit.
    frm[2] = mk(8'hA5);
    send(4'b0100, FL, 1'b0);
    cycle();
    check_val("t1_early_vld", 32'(out_vld), 32'd0);
    cycle();
    check_val("t1_vld", 32'(out_vld), 32'd1);
    check_val("t1_data", 32'(out_data), 32'hA5);
    check_val("t1_ch", 32'(out_ch), 32'd2);
    idle(3);

    // Four lanes complete together: four back-to-back beats in lane order.
    do_reset();
    frm[0] = mk(8'h11); frm[1] = mk(8'h22); frm[2] = mk(8'h33); frm[3] = mk(8'h44);
    send(4'b1111, FL, 1'b0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_val("t2_vld", 32'(out_vld), 32'd1);
      check_val("t2_ch", 32'(out_ch), 32'(k));
      check_val("t2_data", 32'(out_data), 32'((k + 1) * 8'h11));
    end
    cycle();
    check_val("t2_idle", 32'(out_vld), 32'd0);

    // Backpressure overflow: output slot holds lane 0, lane 1 holds 0x5A, 0xC3 is dropped.
    do_reset();
    out_rdy = 1'b0;
    frm[0] = mk(8'h77);
    send(4'b0001, FL, 1'b0);
    frm[1] = mk(8'h5A);
    send(4'b0010, FL, 1'b0);
    frm[1] = mk(8'hC3);
    send(4'b0010, FL, 1'b0);
    idle(2);
    check_val("t3_ovf", 32'(ovf), 32'h2);
    check_val("t3_stall_data", 32'(out_data), 32'h77);
    out_rdy = 1'b1;
    idle(5);
    check_val("t3_nbeats", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check_val("t3_beat0", 32'(got_q[0]), 32'h077);
      check_val("t3_beat1", 32'(got_q[1]), 32'h15A);
    end
    check_val("t3_ovf_sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check_val("t3_ovf_clr", 32'(ovf), 32'h0);

    // Gapped valid pattern followed by a dense frame: no slipped bits.
    do_reset();
    frm[0] = mk(8'hFF);
    send(4'b0001, FL, 1'b1);
    frm[0] = mk(8'h81);
    send(4'b0001, FL, 1'b0);
    idle(4);
    check_val("t4_nbeats", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check_val("t4_beat0", 32'(got_q[0]), 32'h0FF);
      check_val("t4_beat1", 32'(got_q[1]), 32'h081);
    end

    // Reset mid-frame discards the partial frame.
    do_reset();
    frm[3] = mk(8'hFF);
    send(4'b1000, 5, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    got_q.delete();
    frm[3] = mk(8'h3C);
    send(4'b1000, FL, 1'b0);
    idle(4);
    check_val("t5_nbeats", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check_val("t5_beat", 32'(got_q[0]), 32'h33C);

`ifdef DEMUX_LANE_COLLECTOR_PARITY_EN
    do_reset();
    frm[0] = {8'h01, 1'b0};
    send(4'b0001, FL, 1'b0);
    idle(2);
    check_val("t6_data", 32'(out_data), 32'h01);
    check_val("t6_perr_ok", 32'(out_perr), 32'd0);
    frm[0] = {8'h01, 1'b1};
    send(4'b0001, FL, 1'b0);
    idle(2);
    check_val("t6_perr_bad", 32'(out_perr), 32'd1);
`endif

    // Random traffic with varying backpressure, occasional clears and resets.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 100 : (seg % 3 == 1) ? 60 : 15;
      for (int c = 0; c < 500; c++) begin
        lane_vld = 4'($urandom);
        lane_bit = 4'($urandom);
        out_rdy  = ($urandom_range(1, 100) <= rdy_pct);
        ovf_clr  = ($urandom_range(0, 40) == 0);
        rst      = ($urandom_range(0, 600) == 0);
        cycle();
      end
    end
    rst = 1'b0; lane_vld = '0; ovf_clr = 1'b0; out_rdy = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/demux_lane_collector.md
DEMUX_LANE_COLLECTOR -- requirements
Module: demux_lane_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per byte collected per lane.
REQ-002 SHALL have parameter NUM_LANES, default 4, meaning number of serial input lanes; only the value 4 is required to be supported.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, width 1, the single rising-edge clock.
REQ-005 SHALL have port rst, input, width 1, the synchronous active-high reset.
REQ-006 SHALL have port lane_bit, input, width 4, the serial data bit per lane (the demux outputs 0..3).
REQ-007 SHALL have port lane_vld, input, width 4, the per-lane bit-valid qualifier.
REQ-008 SHALL have port out_rdy, input, width 1, the consumer ready.
REQ-009 SHALL have port ovf_clr, input, width 1, which clears all sticky overflow flags.
REQ-010 SHALL have port out_vld, output, width 1, the byte-valid signal.
REQ-011 SHALL have port out_data, output, width DATA_W, the assembled byte.
REQ-012 SHALL have port out_ch, output, width 2, the source lane index.
REQ-013 SHALL have port ovf, output, width 4, the per-lane sticky overflow flags.
REQ-014 SHALL have port out_perr, output, width 1, the parity error flag; this port is present only when PARITY_EN is defined.

Function
REQ-015 SHALL capture lane_bit[i] MSB-first into the lane-i shift register on each cycle with lane_vld[i]=1; bits on cycles with lane_vld[i]=0 SHALL be ignored.
REQ-016 SHALL keep a per-lane bit counter that completes a frame on the bit with lane_vld[i]=1 and counter=FRAME_LEN-1, then wraps to 0; FRAME_LEN is DATA_W without PARITY_EN and DATA_W+1 with it.
REQ-017 SHALL, on frame completion, load the lane hold register and set pending[i] on the next edge if pending[i]=0.
REQ-018 SHALL, on frame completion with pending[i]=1 and no same-cycle grant to lane i, drop the new byte, keep the hold register, and set ovf[i].
REQ-019 SHALL, when frame completion and a grant of lane i occur in the same cycle, load the new byte into hold, keep pending[i]=1, and leave ovf[i] unchanged.
REQ-020 SHALL use an output register with a load condition of out_vld=0 or (out_vld=1 and out_rdy=1).
REQ-021 SHALL, when the output register loads, grant the first pending lane searching round-robin from rr_ptr upward modulo 4.
REQ-022 SHALL, on a grant, load out_data and out_ch, set out_vld=1, clear pending, and set rr_ptr to the granted lane index + 1 (mod 4).
REQ-023 SHALL, when the output register loads and no lane is pending, set out_vld=0 and hold out_data and out_ch.
REQ-024 SHALL hold out_data, out_ch and out_perr stable while out_vld=1 and out_rdy=0.
REQ-025 SHALL produce out_vld no earlier than 2 cycles after the edge sampling the last frame bit (1 cycle pending, 1 cycle output register).
REQ-026 SHALL sustain a throughput of one byte per cycle when out_rdy is held at 1.
REQ-027 SHALL keep ovf[i] sticky until ovf_clr=1; when a set and ovf_clr occur in the same cycle, the set SHALL win.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear all shift registers, counters, hold registers, pending bits, rr_ptr, out_vld, out_data, out_ch, ovf and out_perr to 0.
REQ-029 SHALL discard any partially received frame when reset is asserted mid-frame; the next valid bit after reset SHALL be frame bit 0.

Configuration
REQ-030 SHALL, with macro DEMUX_LANE_COLLECTOR_PARITY_EN defined, treat frame bit DATA_W as an odd-parity bit and set out_perr=1 with the granted byte when the count of ones across all DATA_W+1 bits is even.
REQ-031 SHALL, without the macro, use DATA_W-bit frames and omit out_perr and all parity logic.

Structure
REQ-032 SHALL place DATA_W default, NUM_LANES, and the lane index typedef (2-bit) in shared package demux_collect_pkg.
REQ-033 SHALL implement one sub-module, demux_lane_deser (shift register, counter and frame-complete pulse), instantiated once per lane; hold/pending/arbitration logic SHALL reside in the top module.

Verification
REQ-034 SHALL verify: lane 2 receives 8 valid bits 1,0,1,0,0,1,0,1 with out_rdy=1 -> out_vld=1, out_data=0xA5, out_ch=2, two cycles after the last bit.
REQ-035 SHALL verify: lanes 0..3 complete bytes 0x11, 0x22, 0x33, 0x44 on the same cycle with rr_ptr=0 and out_rdy=1 -> four consecutive beats with out_ch 0,1,2,3.
REQ-036 SHALL verify: out_rdy=0, lane 1 completes 0x5A then 0xC3 -> ovf[1]=1, and 0x5A is delivered once out_rdy=1; asserting ovf_clr then clears ovf to 0.
REQ-037 SHALL verify: lane_vld toggles 1,0,1,0 across a frame of 0xFF -> byte 0xFF with no extra or missed bits.
REQ-038 SHALL verify: rst asserted after 5 bits of lane 3, then 8 bits of 0x3C are sent -> single output 0x3C on ch 3.
REQ-039 SHALL verify, with PARITY_EN: 0x01 with parity bit 0 -> out_perr=0; 0x01 with parity bit 1 -> out_perr=1.
